// File: rtl/enoc_pkt_injector_if.sv
// Core-side and network-side handshake bundle for enoc_pkt_injector.
// slave = injector view, master = core + network driving it.
interface enoc_pkt_injector_if #(
   parameter int ADDR_W    = 4,
   parameter int PAYLOAD_W = 32,
   parameter int SEQ_W     = 8
);
   localparam int PKT_W = SEQ_W + 2 * ADDR_W + PAYLOAD_W;

   logic [PAYLOAD_W-1:0] i_data;
   logic [ADDR_W-1:0]    i_dest;
   logic                 i_data_val;
   logic                 o_en;
   logic [PKT_W-1:0]     o_data;
   logic                 o_data_val;
   logic                 i_en;
   logic [15:0]          o_pkt_count;

   modport slave (
      input  i_data, i_dest, i_data_val, i_en,
      output o_en, o_data, o_data_val, o_pkt_count
   );

   modport master (
      output i_data, i_dest, i_data_val, i_en,
      input  o_en, o_data, o_data_val, o_pkt_count
   );
endinterface

// File: rtl/enoc_pkt_injector.sv
// Network-interface transmitter: stamps core payloads with {seq, src, dest},
// buffers them in a show-ahead FIFO and injects them with an optional gap.
module enoc_pkt_injector #(
   parameter int NODE_ID   = 0,
   parameter int ADDR_W    = 4,
   parameter int PAYLOAD_W = 32,
   parameter int SEQ_W     = 8,
   parameter int DEPTH     = 4,
   parameter int INJ_GAP   = 0
) (
   input logic                clk,
   input logic                reset_n,
   enoc_pkt_injector_if.slave io_bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = SEQ_W + 2 * ADDR_W + PAYLOAD_W;
   localparam int GW = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;
   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'((INJ_GAP > 0) ? INJ_GAP - 1 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   logic [PW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             r_en;
   logic [SEQ_W-1:0] r_seq;
   logic [15:0]      r_pkt_cnt;
   state_t           r_state;
   logic [GW-1:0]    r_gap;
   logic             r_val;

   logic             w_wr;
   logic             w_rd;
   logic [AW:0]      w_count_nxt;

   assign w_wr = io_bus.i_data_val & r_en;
   assign w_rd = r_val & io_bus.i_en;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem     <= '{default: '0};
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_en      <= 1'b0;
         r_seq     <= '0;
         r_pkt_cnt <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr] <= {r_seq, ADDR_W'(NODE_ID), io_bus.i_dest, io_bus.i_data};
            r_wptr        <= r_wptr + 1'b1;
            r_seq         <= r_seq + 1'b1;
         end
         if (w_rd) begin
            r_rptr    <= r_rptr + 1'b1;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
         r_count <= w_count_nxt;
         r_en    <= (w_count_nxt < FULL);
      end
   end

   // IDLE and GAP look at registered occupancy, so a fresh write never bypasses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_gap   <= '0;
         r_val   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_count != '0) begin
                  r_state <= SEND;
                  r_val   <= 1'b1;
               end
            end
            SEND: begin
               if (w_rd) begin
                  if (INJ_GAP > 0) begin
                     r_state <= GAP;
                     r_gap   <= GAP_LOAD;
                     r_val   <= 1'b0;
                  end else if (w_count_nxt == '0) begin
                     r_state <= IDLE;
                     r_val   <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (r_gap == '0) begin
                  if (r_count != '0) begin
                     r_state <= SEND;
                     r_val   <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_val   <= 1'b0;
                  end
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_val   <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.o_data      = r_mem[r_rptr];
   assign io_bus.o_data_val  = r_val;
   assign io_bus.o_en        = r_en;
   assign io_bus.o_pkt_count = r_pkt_cnt;
endmodule
